// File: rtl/arith_pkg.sv
// Shared types and constants for the nibble-serial arithmetic blocks.
package arith_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;
  localparam int NIBBLE_W = 4;
endpackage

// File: rtl/nibble_serial_adder_ctrl_cla4.sv
// 4-bit carry-lookahead adder with carry-in; also exposes the carry into bit 3
// so the controller can form signed overflow on the top nibble.
module cla4_cin (
  input  logic [3:0] A,
  input  logic [3:0] B,
  input  logic       Cin,
  output logic [3:0] Sum,
  output logic       Cout,
  output logic       C3
);
  logic [3:0] g, p;
  logic       c1, c2, c3, c4;

  assign g = A & B;
  assign p = A ^ B;

  assign c1 = g[0] | (p[0] & Cin);
  assign c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & Cin);
  assign c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & Cin);
  assign c4 = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
            | (p[3] & p[2] & p[1] & p[0] & Cin);

  assign Sum  = p ^ {c3, c2, c1, Cin};
  assign Cout = c4;
  assign C3   = c3;
endmodule

// File: rtl/nibble_serial_adder_ctrl.sv
// WIDTH-bit adder built from one shared 4-bit CLA slice, stepped LSB nibble
// first over WIDTH/4 cycles between a valid/ready input and output handshake.
module nibble_serial_adder_ctrl
  import arith_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             busy
);
  localparam int NIBBLES = WIDTH / NIBBLE_W;
  localparam int IW      = $clog2(NIBBLES);
  localparam logic [IW-1:0] LAST = IW'(NIBBLES - 1);

  generate
    if ((WIDTH % NIBBLE_W) != 0 || WIDTH < 8) begin : g_bad_width
      $error("nibble_serial_adder_ctrl: WIDTH must be a multiple of 4 and >= 8");
    end
  endgenerate

  state_t           state;
  logic [IW-1:0]    idx;
  logic             carry;
  logic [WIDTH-1:0] a_sh, b_sh, sum_sh;
  logic             cout_r, ovf_r;

  logic [3:0] n_sum;
  logic       n_cout, n_c3;

  cla4_cin u_cla (
    .A    (a_sh[NIBBLE_W-1:0]),
    .B    (b_sh[NIBBLE_W-1:0]),
    .Cin  (carry),
    .Sum  (n_sum),
    .Cout (n_cout),
    .C3   (n_c3)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      idx    <= '0;
      carry  <= 1'b0;
      a_sh   <= '0;
      b_sh   <= '0;
      sum_sh <= '0;
      cout_r <= 1'b0;
      ovf_r  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          a_sh  <= a;
          b_sh  <= b;
          carry <= cin;
          idx   <= '0;
          state <= RUN;
        end
        RUN: begin
          // Fill from the MSB end so the first nibble lands at bit 0 after the last step.
          sum_sh <= {n_sum, sum_sh[WIDTH-1:NIBBLE_W]};
          a_sh   <= a_sh >> NIBBLE_W;
          b_sh   <= b_sh >> NIBBLE_W;
          carry  <= n_cout;
          idx    <= idx + IW'(1);
          if (idx == LAST) begin
            cout_r <= n_cout;
            ovf_r  <= n_c3 ^ n_cout;
            state  <= DONE;
          end
        end
        DONE: if (out_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign sum       = sum_sh;
  assign cout      = cout_r;
  assign ovf       = ovf_r;
endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// Directed and randomized-gap checks of the nibble-serial adder at WIDTH=16.
module tb_nibble_serial_adder_ctrl;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] a = '0, b = '0;
  logic        cin = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] sum;
  logic        cout, ovf, busy;

  int n_chk = 0;
  int n_fail = 0;
  int hs_cnt = 0;

  logic [15:0] r_sum;
  logic        r_cout, r_ovf;
  int          r_lat, r_busy;
  bit          r_to;

  nibble_serial_adder_ctrl #(.WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovf(ovf), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (rst_n && out_valid && out_ready) hs_cnt++;

  // Drives one operation with out_ready held high and records what came out.
  task automatic run_op(input logic [15:0] xa, input logic [15:0] xb, input logic xc);
    int t;
    @(negedge clk);
    a = xa; b = xb; cin = xc; in_valid = 1'b1;
    t = 0;
    while (!in_ready && t < 50) begin @(negedge clk); t++; end
    @(negedge clk);
    in_valid = 1'b0;
    a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom);
    r_busy = int'(busy);
    r_lat = 0;
    while (!out_valid && r_lat < 50) begin @(negedge clk); r_lat++; r_busy += int'(busy); end
    r_to = !out_valid;
    r_sum = sum; r_cout = cout; r_ovf = ovf;
    @(negedge clk);
  endtask

  task automatic test_reset();
    #1;
    n_chk++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
    n_chk++; if ({sum, cout, ovf} !== 18'h0) begin n_fail++; $display("FAIL reset_result got=%h/%b/%b exp=0000/0/0", sum, cout, ovf); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    out_ready = 1'b1;
    run_op(16'h1234, 16'h4321, 1'b0);
    n_chk++; if (r_to) begin n_fail++; $display("FAIL basic_timeout got=no out_valid exp=out_valid"); end
    n_chk++; if ({r_sum, r_cout, r_ovf} !== {16'h5555, 1'b0, 1'b0}) begin n_fail++; $display("FAIL basic_sum got=%h/%b/%b exp=5555/0/0", r_sum, r_cout, r_ovf); end
    n_chk++; if (r_lat !== 4) begin n_fail++; $display("FAIL basic_latency got=%0d exp=4", r_lat); end
    n_chk++; if (r_busy !== 5) begin n_fail++; $display("FAIL basic_busy_cycles got=%0d exp=5", r_busy); end
    n_chk++; if (busy !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL basic_idle_after got=busy%b ov%b ir%b exp=busy0 ov0 ir1", busy, out_valid, in_ready); end
    n_chk++; if (sum !== 16'h5555) begin n_fail++; $display("FAIL basic_sum_held got=%h exp=5555", sum); end
  endtask

  task automatic test_carry_overflow();
    run_op(16'hFFFF, 16'h0001, 1'b0);
    n_chk++; if ({r_sum, r_cout, r_ovf} !== {16'h0000, 1'b1, 1'b0}) begin n_fail++; $display("FAIL ripple_ffff got=%h/%b/%b exp=0000/1/0", r_sum, r_cout, r_ovf); end
    run_op(16'h00FF, 16'h0000, 1'b1);
    n_chk++; if ({r_sum, r_cout, r_ovf} !== {16'h0100, 1'b0, 1'b0}) begin n_fail++; $display("FAIL ripple_cin got=%h/%b/%b exp=0100/0/0", r_sum, r_cout, r_ovf); end
    run_op(16'h7FFF, 16'h0001, 1'b0);
    n_chk++; if ({r_sum, r_cout, r_ovf} !== {16'h8000, 1'b0, 1'b1}) begin n_fail++; $display("FAIL ovf_pos got=%h/%b/%b exp=8000/0/1", r_sum, r_cout, r_ovf); end
    run_op(16'h8000, 16'h8000, 1'b0);
    n_chk++; if ({r_sum, r_cout, r_ovf} !== {16'h0000, 1'b1, 1'b1}) begin n_fail++; $display("FAIL ovf_neg got=%h/%b/%b exp=0000/1/1", r_sum, r_cout, r_ovf); end
  endtask

  task automatic test_backpressure();
    int t;
    out_ready = 1'b0;
    @(negedge clk);
    a = 16'h1111; b = 16'h2222; cin = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    t = 0;
    while (!out_valid && t < 50) begin @(negedge clk); t++; end
    n_chk++; if (!out_valid) begin n_fail++; $display("FAIL bp_timeout got=no out_valid exp=out_valid"); end
    a = 16'hF0F0; b = 16'h1010; cin = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      n_chk++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || {sum, cout, ovf} !== {16'h3333, 1'b0, 1'b0}) begin
        n_fail++;
        $display("FAIL bp_hold cyc=%0d got=ov%b ir%b %h/%b/%b exp=ov1 ir0 3333/0/0", i, out_valid, in_ready, sum, cout, ovf);
      end
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    n_chk++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_release got=ir%b ov%b exp=ir1 ov0", in_ready, out_valid); end
    @(negedge clk);
    in_valid = 1'b0;
    t = 0;
    while (!out_valid && t < 50) begin @(negedge clk); t++; end
    n_chk++; if ({out_valid, sum, cout, ovf} !== {1'b1, 16'h0101, 1'b1, 1'b0}) begin n_fail++; $display("FAIL bp_next got=ov%b %h/%b/%b exp=ov1 0101/1/0", out_valid, sum, cout, ovf); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_run();
    out_ready = 1'b1;
    @(negedge clk);
    a = 16'hFFFF; b = 16'h0001; cin = 1'b1; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_chk++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1 || sum !== 16'h0000) begin
      n_fail++;
      $display("FAIL midrun_reset got=ov%b busy%b ir%b sum=%h exp=ov0 busy0 ir1 sum=0000", out_valid, busy, in_ready, sum);
    end
    @(negedge clk);
    rst_n = 1'b1;
    run_op(16'hABCD, 16'h1111, 1'b0);
    n_chk++; if ({r_to, r_sum, r_cout, r_ovf} !== {1'b0, 16'hBCDE, 1'b0, 1'b0}) begin n_fail++; $display("FAIL midrun_after got=to%b %h/%b/%b exp=to0 bcde/0/0", r_to, r_sum, r_cout, r_ovf); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] xa, xb;
    logic        xc, e_ovf;
    logic [16:0] full;
    int          h0, t;
    for (int i = 0; i < 20; i++) begin
      xa = 16'($urandom); xb = 16'($urandom); xc = 1'($urandom);
      full = {1'b0, xa} + {1'b0, xb} + {16'h0, xc};
      e_ovf = (xa[15] == xb[15]) && (full[15] != xa[15]);
      h0 = hs_cnt;
      repeat ($urandom_range(0, 3)) @(negedge clk);
      a = xa; b = xb; cin = xc; in_valid = 1'b1;
      t = 0;
      while (!in_ready && t < 50) begin @(negedge clk); t++; end
      @(negedge clk);
      in_valid = 1'b0;
      a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom);
      out_ready = 1'($urandom);
      t = 0;
      while (!out_valid && t < 50) begin @(negedge clk); t++; out_ready = 1'($urandom); end
      out_ready = 1'b0;
      repeat ($urandom_range(0, 2)) @(negedge clk);
      n_chk++;
      if ({out_valid, sum, cout, ovf} !== {1'b1, full[15:0], full[16], e_ovf}) begin
        n_fail++;
        $display("FAIL b2b_result i=%0d got=ov%b %h/%b/%b exp=ov1 %h/%b/%b", i, out_valid, sum, cout, ovf, full[15:0], full[16], e_ovf);
      end
      out_ready = 1'b1;
      @(negedge clk);
      n_chk++; if (hs_cnt !== h0 + 1) begin n_fail++; $display("FAIL b2b_count i=%0d got=%0d exp=%0d", i, hs_cnt - h0, 1); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_carry_overflow();
    test_backpressure();
    test_reset_mid_run();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=still running exp=finished");
    $fatal(1, "timeout");
  end
endmodule
